// File: rtl/dma_rd_axi_master.sv
// dma_rd_axi_master: read DMA engine, one AXI4 INCR burst per request, R beats through a 2-entry skid FIFO.
// Optional macro AXI_RD_4K_SPLIT_EN: a request crossing a 4 KB page is issued as two AR bursts.
module dma_rd_axi_master #(
   parameter int C_M_AXI_ADDR_WIDTH = 64,
   parameter int C_M_AXI_DATA_WIDTH = 512
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          dma_rd_req,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0] dma_rd_addr,
   input  logic [7:0]                    dma_rd_len,
   output logic                          dma_rd_req_ack,
   output logic [C_M_AXI_DATA_WIDTH-1:0] dma_rd_data,
   output logic                          dma_rd_data_valid,
   output logic                          dma_rd_data_last,
   input  logic                          dma_rd_data_taken,
   output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
   output logic [7:0]                    m_axi_arlen,
   output logic [2:0]                    m_axi_arsize,
   output logic [1:0]                    m_axi_arburst,
   output logic                          m_axi_arvalid,
   input  logic                          m_axi_arready,
   input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
   input  logic [1:0]                    m_axi_rresp,
   input  logic                          m_axi_rlast,
   input  logic                          m_axi_rvalid,
   output logic                          m_axi_rready,
   output logic                          rd_err
);
   localparam int BYTES = C_M_AXI_DATA_WIDTH / 8;
   localparam int SIZE  = $clog2(BYTES);

   typedef enum logic [1:0] {S_IDLE, S_AR, S_DATA} state_t;
   state_t r_state, w_next;

   logic [C_M_AXI_ADDR_WIDTH-1:0] r_araddr;
   logic [7:0]                    r_arlen, r_len, r_beat, r_sub_end;
   logic                          r_ack, r_err, r_rready;
   logic [C_M_AXI_DATA_WIDTH-1:0] r_mem_d [2];
   logic                          r_mem_l [2];
   logic                          r_wptr, r_rptr;
   logic [1:0]                    r_cnt, w_cnt_next;
   logic                          w_push, w_pop, w_valid, w_beat, w_sub_done, w_req_done;
   logic [23:0]                   w_off, w_end;
   logic                          w_cross;

   // Byte span of the request within its 4 KB page; beyond 4096 means it crosses
   assign w_off   = {12'd0, dma_rd_addr[11:0]};
   assign w_end   = w_off + ((24'(dma_rd_len) + 24'd1) << SIZE);
   assign w_cross = (w_end > 24'd4096);

`ifdef AXI_RD_4K_SPLIT_EN
   logic [C_M_AXI_ADDR_WIDTH-1:0] r_addr2, w_addr2;
   logic [7:0]                    r_len2, w_b1m1;
   logic [23:0]                   w_b1;
   assign w_b1    = (24'd4096 - w_off) >> SIZE;
   assign w_b1m1  = 8'(w_b1 - 24'd1);
   assign w_addr2 = {dma_rd_addr[C_M_AXI_ADDR_WIDTH-1:12] + (C_M_AXI_ADDR_WIDTH-12)'(1), 12'd0};
`endif

   assign w_valid    = (r_cnt != 2'd0);
   assign w_push     = m_axi_rvalid & r_rready;
   assign w_pop      = w_valid & dma_rd_data_taken;
   assign w_beat     = w_push & (r_state == S_DATA);
   assign w_sub_done = w_beat & (r_beat == r_sub_end);
   assign w_req_done = w_beat & (r_beat == r_len);
   assign w_cnt_next = r_cnt + {1'b0, w_push} - {1'b0, w_pop};

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (dma_rd_req) w_next = S_AR;
         S_AR:    if (m_axi_arready) w_next = S_DATA;
         S_DATA:  if (w_req_done) w_next = S_IDLE;
                  else if (w_sub_done) w_next = S_AR;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      m_axi_arvalid     = (r_state == S_AR);
      m_axi_araddr      = r_araddr;
      m_axi_arlen       = r_arlen;
      m_axi_arsize      = 3'(SIZE);
      m_axi_arburst     = 2'b01;
      m_axi_rready      = r_rready;
      dma_rd_req_ack    = r_ack;
      dma_rd_data       = r_mem_d[r_rptr];
      dma_rd_data_valid = w_valid;
      dma_rd_data_last  = w_valid & r_mem_l[r_rptr];
      rd_err            = r_err;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ack     <= 1'b0;
         r_araddr  <= '0;
         r_arlen   <= 8'd0;
         r_len     <= 8'd0;
         r_beat    <= 8'd0;
         r_sub_end <= 8'd0;
         r_err     <= 1'b0;
`ifdef AXI_RD_4K_SPLIT_EN
         r_addr2   <= '0;
         r_len2    <= 8'd0;
`endif
      end else begin
         r_ack <= (r_state == S_IDLE) & dma_rd_req;
         if (r_state == S_IDLE && dma_rd_req) begin
            r_araddr <= dma_rd_addr;
            r_len    <= dma_rd_len;
            r_beat   <= 8'd0;
`ifdef AXI_RD_4K_SPLIT_EN
            r_addr2  <= w_addr2;
            r_len2   <= dma_rd_len - w_b1m1 - 8'd1;
            if (w_cross) begin
               r_arlen   <= w_b1m1;
               r_sub_end <= w_b1m1;
            end else begin
               r_arlen   <= dma_rd_len;
               r_sub_end <= dma_rd_len;
            end
`else
            r_arlen   <= dma_rd_len;
            r_sub_end <= dma_rd_len;
            if (w_cross) r_err <= 1'b1;
`endif
         end
`ifdef AXI_RD_4K_SPLIT_EN
         // First sub-burst finished: reload AR with the post-boundary remainder
         if (w_sub_done && !w_req_done) begin
            r_araddr  <= r_addr2;
            r_arlen   <= r_len2;
            r_sub_end <= r_len;
         end
`endif
         if (w_beat) r_beat <= r_beat + 8'd1;
         if (w_push && m_axi_rresp != 2'b00) r_err <= 1'b1;
         if (w_beat && m_axi_rlast && r_beat != r_sub_end) r_err <= 1'b1;
      end
   end

   // Skid FIFO; last is tagged from the beat counter at push time
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            r_mem_d[i] <= '0;
            r_mem_l[i] <= 1'b0;
         end
         r_wptr   <= 1'b0;
         r_rptr   <= 1'b0;
         r_cnt    <= 2'd0;
         r_rready <= 1'b0;
      end else begin
         if (w_push) begin
            r_mem_d[r_wptr] <= m_axi_rdata;
            r_mem_l[r_wptr] <= w_req_done;
            r_wptr          <= ~r_wptr;
         end
         if (w_pop) r_rptr <= ~r_rptr;
         r_cnt    <= w_cnt_next;
         r_rready <= (w_cnt_next != 2'd2);
      end
   end
endmodule

// File: tb/tb_dma_rd_axi_master.sv
// Directed bench for dma_rd_axi_master: bench drives the AXI slave side by hand and checks the DMA side.
module tb_dma_rd_axi_master;
   localparam int AW = 64;
   localparam int DW = 512;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          dma_rd_req = 1'b0;
   logic [AW-1:0] dma_rd_addr = '0;
   logic [7:0]    dma_rd_len = 8'd0;
   logic          dma_rd_req_ack;
   logic [DW-1:0] dma_rd_data;
   logic          dma_rd_data_valid, dma_rd_data_last;
   logic          dma_rd_data_taken = 1'b0;
   logic [AW-1:0] m_axi_araddr;
   logic [7:0]    m_axi_arlen;
   logic [2:0]    m_axi_arsize;
   logic [1:0]    m_axi_arburst;
   logic          m_axi_arvalid;
   logic          m_axi_arready = 1'b0;
   logic [DW-1:0] m_axi_rdata = '0;
   logic [1:0]    m_axi_rresp = 2'b00;
   logic          m_axi_rlast = 1'b0;
   logic          m_axi_rvalid = 1'b0;
   logic          m_axi_rready;
   logic          rd_err;

   always #5 clk = ~clk;

   dma_rd_axi_master #(.C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst),
      .dma_rd_req(dma_rd_req), .dma_rd_addr(dma_rd_addr), .dma_rd_len(dma_rd_len),
      .dma_rd_req_ack(dma_rd_req_ack), .dma_rd_data(dma_rd_data),
      .dma_rd_data_valid(dma_rd_data_valid), .dma_rd_data_last(dma_rd_data_last),
      .dma_rd_data_taken(dma_rd_data_taken),
      .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
      .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
      .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .rd_err(rd_err)
   );

   int   n_tests = 0;
   int   n_fail = 0;
   int   g_sent, g_got, g_total;
   logic saw_low;

   function automatic logic [DW-1:0] pat(input int n);
      logic [DW-1:0] r;
      for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = 32'hC0DE_0000 + 32'(n);
      return r;
   endfunction

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      dma_rd_req = 1'b0; m_axi_arready = 1'b0; m_axi_rvalid = 1'b0;
      m_axi_rlast = 1'b0; m_axi_rresp = 2'b00; dma_rd_data_taken = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("rst_ack", dma_rd_req_ack, 0);
      chk("rst_valid", dma_rd_data_valid, 0);
      chk("rst_last", dma_rd_data_last, 0);
      chk("rst_data", dma_rd_data, 0);
      chk("rst_arvalid", m_axi_arvalid, 0);
      chk("rst_araddr", m_axi_araddr, 0);
      chk("rst_arlen", m_axi_arlen, 0);
      chk("rst_rready", m_axi_rready, 0);
      chk("rst_err", rd_err, 0);
      rst = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("rready_after_rst", m_axi_rready, 1);
   endtask

   task automatic do_req(input logic [AW-1:0] addr, input logic [7:0] len);
      int cyc = 0;
      g_sent = 0; g_got = 0; g_total = int'(len) + 1;
      dma_rd_req = 1'b1; dma_rd_addr = addr; dma_rd_len = len;
      while (cyc < 20) begin
         @(posedge clk); @(negedge clk);
         cyc++;
         if (dma_rd_req_ack) break;
      end
      chk("ack_latency", cyc, 1);
      dma_rd_req = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("ack_pulse", dma_rd_req_ack, 0);
   endtask

   task automatic ar_phase(input logic [AW-1:0] addr, input logic [7:0] len);
      int cyc = 0;
      while (!m_axi_arvalid && cyc < 20) begin
         @(posedge clk); @(negedge clk);
         cyc++;
      end
      chk("arvalid", m_axi_arvalid, 1);
      chk("araddr", m_axi_araddr, addr);
      chk("arlen", m_axi_arlen, len);
      chk("arsize", m_axi_arsize, 6);
      chk("arburst", m_axi_arburst, 1);
      m_axi_arready = 1'b1;
      @(posedge clk); @(negedge clk);
      m_axi_arready = 1'b0;
      chk("ar_done", m_axi_arvalid, 0);
   endtask

   // Sends nb R beats; tmode 1 toggles taken every cycle; stops once got_target beats came out
   task automatic r_phase(input int nb, input int rlast_at, input int bad_at, input int tmode,
                          input int got_target);
      int s = 0;
      int cyc = 0;
      saw_low = 1'b0;
      while ((s < nb || g_got < got_target) && cyc < 400) begin
         m_axi_rvalid = (s < nb);
         m_axi_rdata  = pat(g_sent);
         m_axi_rlast  = (s < nb) && (s == rlast_at);
         m_axi_rresp  = (s == bad_at) ? 2'b10 : 2'b00;
         dma_rd_data_taken = (tmode == 0) ? 1'b1 : (cyc % 2 == 0);
         if (!m_axi_rready) saw_low = 1'b1;
         if (dma_rd_data_valid && dma_rd_data_taken) begin
            chk("data", dma_rd_data, pat(g_got));
            chk("last", dma_rd_data_last, (g_got == g_total - 1));
            g_got++;
         end
         if (m_axi_rvalid && m_axi_rready) begin
            s++;
            g_sent++;
         end
         @(posedge clk); @(negedge clk);
         cyc++;
      end
      m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00; dma_rd_data_taken = 1'b0;
      chk("r_phase_bound", (cyc < 400), 1);
   endtask

   initial begin
      @(negedge clk);
      do_reset();

      // 1: plain 4-beat burst
      do_req(64'h1000, 8'd3);
      ar_phase(64'h1000, 8'd3);
      r_phase(4, 3, -1, 0, 4);
      chk("t1_drained", dma_rd_data_valid, 0);
      chk("t1_err", rd_err, 0);

      // 2: consumer stalls every other cycle
      do_req(64'h2000, 8'd7);
      ar_phase(64'h2000, 8'd7);
      r_phase(8, 7, -1, 1, 8);
      chk("t2_rready_dropped", saw_low, 1);
      chk("t2_count", g_got, 8);
      chk("t2_err", rd_err, 0);

      // 3: SLVERR on beat 2, sticky
      do_req(64'h4000, 8'd3);
      ar_phase(64'h4000, 8'd3);
      r_phase(4, 3, 1, 0, 4);
      chk("t3_err", rd_err, 1);
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("t3_err_sticky", rd_err, 1);
      do_reset();

      // 4: early rlast on beat 2, burst still ends on the counter
      do_req(64'h5000, 8'd3);
      ar_phase(64'h5000, 8'd3);
      r_phase(4, 1, -1, 0, 4);
      chk("t4_err", rd_err, 1);
      do_req(64'h5100, 8'd0);
      ar_phase(64'h5100, 8'd0);
      r_phase(1, 0, -1, 0, 1);
      do_reset();

      // 5: request crossing a 4 KB page
      do_req(64'hFC0, 8'd1);
`ifdef AXI_RD_4K_SPLIT_EN
      ar_phase(64'hFC0, 8'd0);
      r_phase(1, 0, -1, 0, 1);
      chk("t5_no_second_ack", dma_rd_req_ack, 0);
      ar_phase(64'h1000, 8'd0);
      r_phase(1, 0, -1, 0, 2);
      chk("t5_err", rd_err, 0);
`else
      ar_phase(64'hFC0, 8'd1);
      r_phase(2, 1, -1, 0, 2);
      chk("t5_err", rd_err, 1);
`endif
      chk("t5_count", g_got, 2);

      // 6: reset mid-burst with a beat still buffered, then a clean request
      do_req(64'h6000, 8'd7);
      ar_phase(64'h6000, 8'd7);
      r_phase(2, 7, -1, 0, 1);
      chk("t6_buffered", dma_rd_data_valid, 1);
      do_reset();
      do_req(64'h7000, 8'd1);
      ar_phase(64'h7000, 8'd1);
      r_phase(2, 1, -1, 0, 2);
      chk("t6_err", rd_err, 0);
      chk("t6_drained", dma_rd_data_valid, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
